// File: rtl/score_digit_scanner_if.sv
// Score-to-display bus: load request and score in, scanned digit code and enables out.
interface score_digit_scanner_if;
  logic [13:0] value;
  logic        load;
  logic        blank_lz;
  logic        busy;
  logic [3:0]  digit_data;
  logic [3:0]  anode_n;

  modport master (output value, load, blank_lz, input busy, digit_data, anode_n);
  modport slave  (input value, load, blank_lz, output busy, digit_data, anode_n);
endinterface

// File: rtl/score_digit_scanner.sv
// Binary score to 4-digit BCD (sequential double-dabble) with a time-multiplexed
// digit scan that feeds a shared 7-segment decoder.
module score_digit_scanner #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic                  clk,
  input logic                  rst_n,
  score_digit_scanner_if.slave bus
);

  localparam int unsigned VAL_W  = 14;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned MAX_SCORE = 9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [VAL_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]    work_q, work_d;
  logic [BCD_W-1:0]    disp_q, disp_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                busy_q, busy_d;
  logic [BCD_W-1:0]    adj_c;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          idx_q;
  logic                lz_c;

  // Add-3 correction on every BCD nibble >= 5 before the shift
  always_comb begin
    adj_c = work_q;
    for (int i = 0; i < 4; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      disp_q  <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      disp_q  <= disp_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    disp_d  = disp_q;
    step_d  = step_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          bin_d   = (bus.value > VAL_W'(MAX_SCORE)) ? VAL_W'(MAX_SCORE) : bus.value;
          work_d  = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        {work_d, bin_d} = {adj_c[BCD_W-2:0], bin_q, 1'b0};
        if (step_q == STEP_W'(VAL_W - 1)) begin
          state_d = COMMIT;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      COMMIT: begin
        // Display only updates here, so the scan never shows partial results
        disp_d  = work_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Free-running scan divider and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Leading-zero detect: this digit and all more significant ones are zero
  always_comb begin
    case (idx_q)
      2'd1:    lz_c = (disp_q[15:4]  == 12'd0);
      2'd2:    lz_c = (disp_q[15:8]  == 8'd0);
      2'd3:    lz_c = (disp_q[15:12] == 4'd0);
      default: lz_c = 1'b0;
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.anode_n    = ~(4'b0001 << idx_q);
  assign bus.digit_data = (bus.blank_lz && lz_c) ? 4'hF : disp_q[{idx_q, 2'b00} +: 4];

endmodule

// File: tb/tb_score_digit_scanner.sv
// Self-checking bench for score_digit_scanner: table vectors, random loads vs an
// arithmetic display model, and hand sequences for drop/accept and mid-conversion reset.
module tb_score_digit_scanner;

  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  score_digit_scanner_if bus();

  score_digit_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ticks;
  int model_val = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ticks <= 0;
    else        ticks <= ticks + 1;
  end

  typedef struct {
    int          value;
    bit          blank;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  // Expected 4-digit code word straight from the decimal value
  function automatic logic [15:0] enc(input int v, input bit b);
    logic [15:0] r;
    int s, p;
    s = (v > 9999) ? 9999 : v;
    p = 1;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (b && i > 0 && s < p) r[4*i +: 4] = 4'hF;
      else                     r[4*i +: 4] = 4'((s / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare the currently scanned digit against the expected code word
  task automatic check_cycle(input logic [15:0] exp, input string name);
    int idx;
    logic [3:0] ea, ed;
    idx = (ticks / SCAN_DIV) % 4;
    ea = ~(4'b0001 << idx);
    ed = exp[4*idx +: 4];
    check(name, {24'd0, bus.anode_n, bus.digit_data}, {24'd0, ea, ed});
  endtask

  task automatic check_display(input logic [15:0] exp, input string name);
    for (int c = 0; c < 4 * SCAN_DIV; c++) begin
      check_cycle(exp, name);
      @(negedge clk);
    end
  endtask

  task automatic pulse_load(input int v);
    bus.value = 14'(v);
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; old digits must hold until commit
  task automatic finish_conv(input int old_val, input logic [15:0] exp_new, input string name);
    int cnt;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      check_cycle(enc(old_val, bus.blank_lz), {name, "_hold"});
      cnt++;
      @(negedge clk);
    end
    check({name, "_busy_len"}, 32'(cnt), 32'd15);
    check_display(exp_new, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    bit b;

    vecs[0] = '{1234,  1'b0, 16'h1234};
    vecs[1] = '{12000, 1'b0, 16'h9999};
    vecs[2] = '{9999,  1'b0, 16'h9999};
    vecs[3] = '{10000, 1'b0, 16'h9999};
    vecs[4] = '{7,     1'b1, 16'hFFF7};
    vecs[5] = '{0,     1'b1, 16'hFFF0};
    vecs[6] = '{1005,  1'b0, 16'h1005};
    vecs[7] = '{1005,  1'b1, 16'h1005};

    bus.value    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(bus.busy),       32'd0);
    check("rst_anode", 32'(bus.anode_n),    32'hE);
    check("rst_digit", 32'(bus.digit_data), 32'h0);
    rst_n = 1'b1;

    // Idle scan of zeros
    check_display(16'h0000, "idle_scan");

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      bus.blank_lz = vecs[i].blank;
      pulse_load(vecs[i].value);
      finish_conv(model_val, vecs[i].exp, $sformatf("vec%0d", i));
      model_val = (vecs[i].value > 9999) ? 9999 : vecs[i].value;
    end

    // Randomised loads against the decimal model
    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 16383));
      b = 1'($urandom % 2);
      bus.blank_lz = b;
      pulse_load(v);
      finish_conv(model_val, enc(v, b), $sformatf("rnd%0d", i));
      model_val = (v > 9999) ? 9999 : v;
    end

    // Loads during conversion and at the commit edge are dropped
    bus.blank_lz = 1'b0;
    pulse_load(42);
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("drop_busy%0d", c), 32'(bus.busy), 32'd1);
      bus.value = 14'd99;
      bus.load  = (c == 5 || c == 15);
      @(negedge clk);
    end
    check("drop_busy_fall", 32'(bus.busy), 32'd0);
    check_cycle(enc(42, 1'b0), "drop_disp42");
    // Load on the first edge after busy falls is accepted
    pulse_load(77);
    check("accept_busy", 32'(bus.busy), 32'd1);
    finish_conv(42, 16'h0077, "accept77");
    model_val = 77;

    // Reset in the middle of a conversion
    pulse_load(5678);
    repeat (7) @(negedge clk);
    check("mid_busy8", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(bus.busy),       32'd0);
    check("mid_rst_anode", 32'(bus.anode_n),    32'hE);
    check("mid_rst_digit", 32'(bus.digit_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_val = 0;
    check_display(16'h0000, "post_rst");
    pulse_load(31);
    finish_conv(0, 16'h0031, "post_rst31");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
